// File: rtl/fft_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_seq_ctrl
// Brief    : Radix-2 DIT FFT sequencer; issues butterfly address/twiddle
//            pairs stage by stage with pipeline gaps and a final drain.
// Revision : 1.0 - initial release
// ============================================================================
module fft_seq_ctrl #(
    parameter  int N_POINTS     = 8,
    parameter  int BFLY_LATENCY = 2,
    localparam int LOG2N        = $clog2(N_POINTS),
    localparam int AW           = LOG2N
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          fft_start,
    input  logic          fft_stall,
    input  logic          fft_abort,
    output logic          bfly_valid,
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_b,
    output logic [AW-2:0] twiddle_idx,
    output logic [AW-1:0] stage,
    output logic          busy,
    output logic          fft_done
);

    localparam int            c_CW         = 4;
    localparam logic [AW-1:0] c_ONE        = AW'(1);
    localparam logic [AW-1:0] c_HALF       = AW'(N_POINTS / 2);
    localparam logic [AW-1:0] c_LAST_STAGE = AW'(LOG2N - 1);
    localparam logic [c_CW-1:0] c_LAT_M1   = c_CW'(BFLY_LATENCY - 1);

    generate
        if ((N_POINTS < 8) || (N_POINTS > 1024) || ((1 << LOG2N) != N_POINTS)) begin : g_bad_npoints
            $error("fft_seq_ctrl: N_POINTS must be a power of two in 8..1024");
        end
        if ((BFLY_LATENCY < 1) || (BFLY_LATENCY > 8)) begin : g_bad_latency
            $error("fft_seq_ctrl: BFLY_LATENCY must be in 1..8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_GAP   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state,  w_state_n;
    logic [AW-1:0]   r_k,      w_k_n;
    logic [AW-1:0]   r_stage,  w_stage_n;
    logic [c_CW-1:0] r_cnt,    w_cnt_n;
    logic            r_valid,  w_valid_n;
    logic [AW-1:0]   r_addr_a, w_addr_a_n;
    logic [AW-1:0]   r_addr_b, w_addr_b_n;
    logic [AW-2:0]   r_tw,     w_tw_n;

    logic            w_issue;
    logic [AW-1:0]   w_iss_k;
    logic [AW-1:0]   w_iss_stage;
    logic [AW-1:0]   w_half;
    logic [AW-1:0]   w_pos;
    logic [AW-1:0]   w_calc_a;
    logic [AW-1:0]   w_calc_b;
    logic [AW-2:0]   w_calc_tw;

    // Addressing for the butterfly about to be registered onto the outputs.
    always_comb begin
        w_half    = c_ONE << w_iss_stage;
        w_pos     = w_iss_k & (w_half - c_ONE);
        w_calc_a  = ((w_iss_k >> w_iss_stage) << (w_iss_stage + c_ONE)) | w_pos;
        w_calc_b  = w_calc_a + w_half;
        w_calc_tw = (AW-1)'(w_pos << (c_LAST_STAGE - w_iss_stage));
    end

    always_comb begin
        w_state_n   = r_state;
        w_k_n       = r_k;
        w_stage_n   = r_stage;
        w_cnt_n     = r_cnt;
        w_valid_n   = 1'b0;
        w_addr_a_n  = r_addr_a;
        w_addr_b_n  = r_addr_b;
        w_tw_n      = r_tw;
        w_issue     = 1'b0;
        w_iss_k     = r_k;
        w_iss_stage = r_stage;

        case (r_state)
            S_IDLE: begin
                if (fft_start) begin
                    w_state_n   = S_RUN;
                    w_issue     = 1'b1;
                    w_iss_k     = '0;
                    w_iss_stage = '0;
                end
            end
            S_RUN: begin
                if (fft_abort) begin
                    w_state_n = S_IDLE;
                end else if (r_k == c_HALF) begin
                    // Every butterfly of this stage has been presented.
                    w_state_n = (r_stage == c_LAST_STAGE) ? S_DRAIN : S_GAP;
                    w_cnt_n   = c_LAT_M1;
                end else if (!fft_stall) begin
                    w_issue = 1'b1;
                end
            end
            S_GAP: begin
                if (fft_abort) begin
                    w_state_n = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_n   = S_RUN;
                    w_issue     = 1'b1;
                    w_iss_k     = '0;
                    w_iss_stage = r_stage + c_ONE;
                end else begin
                    w_cnt_n = r_cnt - c_CW'(1);
                end
            end
            S_DRAIN: begin
                if (fft_abort) begin
                    w_state_n = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_n = S_DONE;
                end else begin
                    w_cnt_n = r_cnt - c_CW'(1);
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        if (w_issue) begin
            w_valid_n  = 1'b1;
            w_k_n      = w_iss_k + c_ONE;
            w_stage_n  = w_iss_stage;
            w_addr_a_n = w_calc_a;
            w_addr_b_n = w_calc_b;
            w_tw_n     = w_calc_tw;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_stage  <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_tw     <= '0;
        end else begin
            r_state  <= w_state_n;
            r_k      <= w_k_n;
            r_stage  <= w_stage_n;
            r_cnt    <= w_cnt_n;
            r_valid  <= w_valid_n;
            r_addr_a <= w_addr_a_n;
            r_addr_b <= w_addr_b_n;
            r_tw     <= w_tw_n;
        end
    end

    assign bfly_valid  = r_valid;
    assign addr_a      = r_addr_a;
    assign addr_b      = r_addr_b;
    assign twiddle_idx = r_tw;
    assign stage       = r_stage;
    assign busy        = (r_state != S_IDLE);
    assign fft_done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fft_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_seq_ctrl
// Brief    : Scoreboard bench for fft_seq_ctrl (8/2 and 16/1 configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_seq_ctrl;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    int cyc = 0;
    always @(posedge tb_clk) cyc <= cyc + 1;

    logic       n_rst;
    logic       fft_start, fft_stall, fft_abort;
    logic       bfly_valid, busy, fft_done;
    logic [2:0] addr_a, addr_b, stage;
    logic [1:0] twiddle_idx;

    logic       fft_start16, fft_stall16, fft_abort16;
    logic       bfly_valid16, busy16, fft_done16;
    logic [3:0] addr_a16, addr_b16, stage16;
    logic [2:0] twiddle_idx16;

    fft_seq_ctrl #(.N_POINTS(8), .BFLY_LATENCY(2)) dut (
        .clk(tb_clk), .n_rst(n_rst),
        .fft_start(fft_start), .fft_stall(fft_stall), .fft_abort(fft_abort),
        .bfly_valid(bfly_valid), .addr_a(addr_a), .addr_b(addr_b),
        .twiddle_idx(twiddle_idx), .stage(stage), .busy(busy), .fft_done(fft_done)
    );

    fft_seq_ctrl #(.N_POINTS(16), .BFLY_LATENCY(1)) dut16 (
        .clk(tb_clk), .n_rst(n_rst),
        .fft_start(fft_start16), .fft_stall(fft_stall16), .fft_abort(fft_abort16),
        .bfly_valid(bfly_valid16), .addr_a(addr_a16), .addr_b(addr_b16),
        .twiddle_idx(twiddle_idx16), .stage(stage16), .busy(busy16), .fft_done(fft_done16)
    );

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int st;
    } exp_t;

    localparam int c_A8    [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    localparam int c_B8    [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    localparam int c_TW8   [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    localparam int c_NORM  [12] = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};
    localparam int c_STALL [12] = '{1, 2, 3, 4, 7, 8, 12, 13, 16, 17, 18, 19};

    exp_t q8[$];
    exp_t q16[$];
    int   t0     = 0;
    int   done8  = -1;
    int   done16 = -1;
    int   nb16   = 0;
    int   checks = 0;
    int   errors = 0;

    always @(negedge tb_clk) begin : mon8
        exp_t e;
        if (bfly_valid) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL bfly8_extra: got cyc=%0d a=%0d b=%0d tw=%0d, want no butterfly",
                         cyc - t0 + 1, addr_a, addr_b, twiddle_idx);
            end else begin
                e = q8.pop_front();
                if (e.cyc != cyc - t0 + 1 || e.a != int'(addr_a) || e.b != int'(addr_b) ||
                    e.tw != int'(twiddle_idx) || e.st != int'(stage)) begin
                    errors++;
                    $display("FAIL bfly8: got cyc=%0d a=%0d b=%0d tw=%0d st=%0d, want cyc=%0d a=%0d b=%0d tw=%0d st=%0d",
                             cyc - t0 + 1, addr_a, addr_b, twiddle_idx, stage,
                             e.cyc, e.a, e.b, e.tw, e.st);
                end
            end
        end
        if (fft_done && done8 < 0) done8 = cyc - t0 + 1;
    end

    always @(negedge tb_clk) begin : mon16
        exp_t e;
        if (bfly_valid16) begin
            checks++;
            nb16++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL bfly16_extra: got cyc=%0d a=%0d b=%0d, want no butterfly",
                         cyc - t0 + 1, addr_a16, addr_b16);
            end else begin
                e = q16.pop_front();
                if (e.cyc != cyc - t0 + 1 || e.a != int'(addr_a16) || e.b != int'(addr_b16) ||
                    e.tw != int'(twiddle_idx16) || e.st != int'(stage16)) begin
                    errors++;
                    $display("FAIL bfly16: got cyc=%0d a=%0d b=%0d tw=%0d st=%0d, want cyc=%0d a=%0d b=%0d tw=%0d st=%0d",
                             cyc - t0 + 1, addr_a16, addr_b16, twiddle_idx16, stage16,
                             e.cyc, e.a, e.b, e.tw, e.st);
                end
            end
        end
        if (fft_done16 && done16 < 0) done16 = cyc - t0 + 1;
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc - t0 + 1 < n) @(negedge tb_clk);
    endtask

    task automatic push8(input int idx, input int c);
        exp_t e;
        e.cyc = c;
        e.a   = c_A8[idx];
        e.b   = c_B8[idx];
        e.tw  = c_TW8[idx];
        e.st  = idx / 4;
        q8.push_back(e);
    endtask

    task automatic push_norm(input int count);
        for (int i = 0; i < count; i++) push8(i, c_NORM[i]);
    endtask

    task automatic start8(input logic with_abort);
        fft_start = 1'b1;
        fft_abort = with_abort;
        t0        = cyc + 1;
        done8     = -1;
        @(negedge tb_clk);
        fft_start = 1'b0;
        fft_abort = 1'b0;
    endtask

    task automatic finish_normal(input string tag);
        wait_cyc(19);
        chk({tag, "_busy19"}, int'(busy), 1);
        chk({tag, "_done19"}, int'(fft_done), 1);
        wait_cyc(20);
        chk({tag, "_busy20"}, int'(busy), 0);
        wait_cyc(24);
        chk({tag, "_done_cycle"}, done8, 19);
        chk({tag, "_queue_left"}, q8.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(bfly_valid), 0);
        chk({tag, "_addr_a"}, int'(addr_a), 0);
        chk({tag, "_addr_b"}, int'(addr_b), 0);
        chk({tag, "_tw"}, int'(twiddle_idx), 0);
        chk({tag, "_stage"}, int'(stage), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(fft_done), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        n_rst       = 1'b1;
        fft_start   = 1'b0;
        fft_stall   = 1'b0;
        fft_abort   = 1'b0;
        fft_start16 = 1'b0;
        fft_stall16 = 1'b0;
        fft_abort16 = 1'b0;

        // Reset takes effect before the first clock edge.
        #1 n_rst = 1'b0;
        #2;
        chk_zero("rst_async");
        chk("rst16_busy", int'(busy16), 0);
        chk("rst16_valid", int'(bfly_valid16), 0);
        repeat (2) @(negedge tb_clk);

        // Normal run, started on the first edge after reset release.
        n_rst = 1'b1;
        push_norm(12);
        start8(1'b0);
        finish_normal("normal");

        // Three stall cycles in stage 1.
        for (int i = 0; i < 12; i++) push8(i, c_STALL[i]);
        start8(1'b0);
        wait_cyc(8);
        fft_stall = 1'b1;
        wait_cyc(10);
        chk("stall_valid", int'(bfly_valid), 0);
        chk("stall_hold_a", int'(addr_a), 1);
        chk("stall_hold_b", int'(addr_b), 3);
        chk("stall_hold_tw", int'(twiddle_idx), 2);
        wait_cyc(11);
        fft_stall = 1'b0;
        wait_cyc(27);
        chk("stall_done_cycle", done8, 22);
        chk("stall_queue_left", q8.size(), 0);

        // Start pulses while busy and in the DONE cycle are ignored.
        push_norm(12);
        start8(1'b0);
        wait_cyc(8);
        fft_start = 1'b1;
        wait_cyc(9);
        fft_start = 1'b0;
        wait_cyc(19);
        chk("ign_done19", int'(fft_done), 1);
        fft_start = 1'b1;
        wait_cyc(20);
        fft_start = 1'b0;
        chk("ign_busy20", int'(busy), 0);
        wait_cyc(21);
        chk("ign_busy21", int'(busy), 0);
        wait_cyc(24);
        chk("ign_done_cycle", done8, 19);
        chk("ign_queue_left", q8.size(), 0);

        // Abort in stage 1, then a clean rerun.
        push_norm(8);
        start8(1'b0);
        wait_cyc(10);
        fft_abort = 1'b1;
        wait_cyc(11);
        fft_abort = 1'b0;
        chk("abort_busy11", int'(busy), 0);
        chk("abort_valid11", int'(bfly_valid), 0);
        wait_cyc(25);
        chk("abort_no_done", done8, -1);
        chk("abort_queue_left", q8.size(), 0);
        push_norm(12);
        start8(1'b0);
        finish_normal("rerun");

        // Start and abort together in IDLE: start wins.
        push_norm(12);
        start8(1'b1);
        finish_normal("start_abort");

        // Asynchronous reset mid-cycle in stage 2.
        push_norm(10);
        start8(1'b0);
        wait_cyc(14);
        #2 n_rst = 1'b0;
        #1;
        chk_zero("rst_mid");
        wait_cyc(22);
        chk("rst_mid_no_done", done8, -1);
        chk("rst_mid_queue_left", q8.size(), 0);
        n_rst = 1'b1;
        push_norm(12);
        start8(1'b0);
        finish_normal("post_rst");

        // 16-point, latency 1.
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) begin
                exp_t e;
                int half;
                int pos;
                half  = 1 << s;
                pos   = k % half;
                e.a   = (k / half) * 2 * half + pos;
                e.b   = e.a + half;
                e.tw  = pos * (1 << (3 - s));
                e.st  = s;
                e.cyc = 1 + s * 9 + k;
                q16.push_back(e);
            end
        end
        nb16        = 0;
        done16      = -1;
        fft_start16 = 1'b1;
        t0          = cyc + 1;
        @(negedge tb_clk);
        fft_start16 = 1'b0;
        wait_cyc(37);
        chk("n16_done37", int'(fft_done16), 1);
        wait_cyc(40);
        chk("n16_done_cycle", done16, 37);
        chk("n16_count", nb16, 32);
        chk("n16_queue_left", q16.size(), 0);
        chk("n16_busy_end", int'(busy16), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 Parameter N_POINTS, default 8: FFT size; SHALL be a power of two, 8..1024.
REQ-002 Parameter BFLY_LATENCY, default 2: butterfly datapath latency in cycles, range 1..8.
REQ-003 Derived LOG2N = log2(N_POINTS); AW = LOG2N.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 n_rst  in  1  asynchronous, active-low reset.
REQ-006 fft_start  in  1  one-cycle request to begin a transform.
REQ-007 fft_stall  in  1  hold the issue pointer this cycle; a butterfly is not issued.
REQ-008 fft_abort  in  1  cancel the transform in progress.
REQ-009 bfly_valid  out  1  addr_a, addr_b and twiddle_idx are valid this cycle.
REQ-010 addr_a  out  AW  upper-leg data address.
REQ-011 addr_b  out  AW  lower-leg data address.
REQ-012 twiddle_idx  out  AW-1  twiddle ROM index.
REQ-013 stage  out  AW  current stage number, 0..LOG2N-1.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 fft_done  out  1  one-cycle pulse at normal completion.

Function
REQ-016 FSM states SHALL be IDLE, RUN, GAP, DRAIN and DONE.
REQ-017 IDLE -> RUN when fft_start=1 at a clock edge; stage=0 and the butterfly counter k=0.
- fft_start outside IDLE is ignored: no restart, no queuing.
REQ-018 RUN issue rules:
- Each cycle with fft_stall=0: bfly_valid=1 and k increments.
- Each cycle with fft_stall=1: bfly_valid=0; k, stage and the address outputs hold.
REQ-019 Radix-2 DIT addressing, with half=2^stage, grp=k>>stage, pos=k&(half-1):
- addr_a = grp*2*half + pos
- addr_b = addr_a + half
- twiddle_idx = pos << (LOG2N-1-stage)
- All arithmetic is unsigned, AW bits wide, and never wraps for legal k.
REQ-020 End of stage: after issuing k=N_POINTS/2-1 with stage<LOG2N-1, go RUN -> GAP.
- GAP lasts exactly BFLY_LATENCY cycles; fft_stall has no effect in GAP.
- Then stage increments, k=0, and the FSM returns to RUN.
REQ-021 After issuing the last butterfly of stage LOG2N-1, go RUN -> DRAIN for exactly BFLY_LATENCY cycles, then DONE.
REQ-022 DONE lasts one cycle: fft_done=1, busy=1, then IDLE.
- fft_start in the DONE cycle is ignored.
REQ-023 fft_abort=1 in any non-IDLE state:
- Next state is IDLE; fft_done is not asserted.
- Abort has priority over stall and over every state transition.
- In IDLE, fft_abort is ignored.
REQ-024 fft_abort and fft_start both high while in IDLE: start wins.
REQ-025 bfly_valid SHALL be 0 in IDLE, GAP, DRAIN and DONE.
REQ-026 The address outputs are registered and hold their last value when bfly_valid=0.
REQ-027 A normal transform with no stalls SHALL take exactly LOG2N*N_POINTS/2 + LOG2N*BFLY_LATENCY + 1 cycles from the start edge through the DONE cycle inclusive.

Reset
REQ-028 n_rst=0 SHALL immediately force the following, with no clock required:
- state=IDLE, k=0, stage=0
- addr_a=0, addr_b=0, twiddle_idx=0
- bfly_valid=0, busy=0, fft_done=0
REQ-029 Reset asserted mid-transform SHALL abandon it without a fft_done pulse.
REQ-030 After reset is released, the block SHALL accept fft_start on the first clock edge.

Verification (N_POINTS=8, BFLY_LATENCY=2; start sampled at edge T0)
REQ-031 Normal run -> the following sequence:
- Cycles T0+1..4: bfly_valid=1 with (a,b,tw) = (0,1,0), (2,3,0), (4,5,0), (6,7,0).
- Cycles 5-6: GAP.
- Cycles 7-10: (0,2,0), (1,3,2), (4,6,0), (5,7,2).
- Cycles 11-12: GAP.
- Cycles 13-16: (0,4,0), (1,5,1), (2,6,2), (3,7,3).
- Cycles 17-18: DRAIN.
- Cycle 19: fft_done=1.
- Cycle 20: busy=0.
REQ-032 fft_stall=1 for 3 cycles during stage 1 -> addresses hold, bfly_valid=0 for those cycles, and fft_done moves to T0+22.
REQ-033 fft_start pulsed at T0+8 and in the DONE cycle -> no effect on sequence or timing.
REQ-034 fft_abort at T0+10 -> busy=0 at T0+11 and no fft_done; a new fft_start then reproduces REQ-031 exactly.
REQ-035 n_rst=0 asynchronously at T0+14 (mid-clock) -> all outputs are 0 before the next edge and no fft_done.
REQ-036 Repeat REQ-031 with N_POINTS=16, BFLY_LATENCY=1 -> 32 valid butterflies and fft_done at T0+37.
